shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the execute datapath.
//  Takes a binary shift amount rather than a one-hot one. Supports logical left, logical right,
//  arithmetic right and optional rotate-left.
//  Uses valid/ready handshakes on input and output with full back-pressure.
//  Sustains one operation per cycle and completes each operation in a fixed latency of PIPE cycles.
// PARAMETERS
//  WIDTH  32  data width; power of two, 8..64
//  PIPE   2   register stages, 1..$clog2(WIDTH); also the latency in cycles
//  TAGW   4   width of the tag carried alongside each operation
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      pipeline can accept this cycle
//  in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//  in_amt     in   SHW    shift amount, SHW=$clog2(WIDTH), unsigned
//  in_data    in   WIDTH  operand
//  in_tag     in   TAGW   opaque tag, returned unchanged
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  result
//  out_tag    out  TAGW   tag of the result
//  out_err    out  1      op is unsupported in this build
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; out_valid=0, out_data=0, out_tag=0, out_err=0.
//    in_ready=1 once reset is released.
//  - Transfers: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
//  - Stage advance: stage k advances when it is empty or stage k+1 advances.
//    The last stage advances when it is empty or out_ready=1.
//    in_ready is stage 0's advance term; the ready path through the chain is combinational.
//  - Throughput: one op per cycle while out_ready=1.
//    Result appears exactly PIPE cycles after the input transfer when there is no stall.
//  - Capacity: the pipeline holds PIPE ops when stalled. No op is dropped or duplicated, and order is preserved.
//  - Datapath: log-shifter with SHW levels (1,2,4,..).
//    Levels are split across the PIPE stages in order, ceil(SHW/PIPE) levels per stage, the last stage taking the remainder.
//    Amount bits for later levels, op and tag travel with the data.
//  - SLL: zero fill from the LSB. SRL: zero fill from the MSB. SRA: fill with in_data[WIDTH-1].
//  - in_amt=0: result equals in_data for every op.
//  - in_amt is SHW bits wide, so the maximum shift is WIDTH-1. No out-of-range case exists.
//  - The output register holds its value while out_valid&!out_ready.
//    out_data is don't-care-stable at 0 only after reset; otherwise it holds the last result.
//  - Reset mid-operation: every in-flight op is discarded and no result is emitted for it.
//  - Simultaneous in/out transfer on a full pipeline: legal, occupancy unchanged.
// CONFIGURATION
//  SHIFTER_ROTATE_EN defined:
//    op 11 = ROL; bits shifted out of the MSB re-enter at the LSB; out_err=0.
//  SHIFTER_ROTATE_EN undefined:
//    rotate path not built; op 11 completes normally with out_data=0 and out_err=1.
//    out_err=0 for every other op.
// TESTING (WIDTH=32, PIPE=2, SHIFTER_ROTATE_EN defined unless stated)
//  - SLL 0x0000_0001 amt 31, out_ready=1 -> 0x8000_0000, out_valid exactly 2 cycles after accept.
//  - SRL 0x8000_0000 amt 4 -> 0x0800_0000; SRA same -> 0xF800_0000; SRA 0x7000_0000 amt 4 -> 0x0700_0000.
//  - ROL 0x8000_0001 amt 1 -> 0x0000_0003.
//    Without the macro -> out_data 0x0, out_err=1, out_tag preserved.
//  - Back-to-back ops, tags 1..6, out_ready=0 from cycle 2:
//    in_ready drops after 2 accepts, out holds tag 1.
//    Release -> tags 1..6 in order, 1 per cycle.
//  - amt 0 for each op on 0xA5A5_5A5A -> 0xA5A5_5A5A, out_err=0.
//  - Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately.
//    After release no stale result appears and in_ready=1.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined log barrel shifter (SLL/SRL/SRA, ROL when SHIFTER_ROTATE_EN is defined)
// with valid/ready handshakes, full back-pressure and a fixed latency of PIPE cycles.
// Without SHIFTER_ROTATE_EN the rotate path is not built: op 11 returns 0 with out_err=1.
module shifter_pipe #(
   parameter int WIDTH = 32,
   parameter int PIPE  = 2,
   parameter int TAGW  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_op,
   input  logic [$clog2(WIDTH)-1:0] in_amt,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [TAGW-1:0]          in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAGW-1:0]          out_tag,
   output logic                     out_err
);
   localparam int SHW = $clog2(WIDTH);
   localparam int LPS = (SHW + PIPE - 1) / PIPE;
`ifdef SHIFTER_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] op, input int s);
      logic signed [WIDTH-1:0] sra;
      sra = $signed(d) >>> s;
      step = op == 2'b00 ? d << s :
             op == 2'b01 ? d >> s :
             op == 2'b10 ? sra :
`ifdef SHIFTER_ROTATE_EN
                           (d << s) | (d >> (WIDTH - s));
`else
                           d;
`endif
   endfunction

   // Applies the log-shifter levels lo..hi-1 selected by the amount bits.
   function automatic logic [WIDTH-1:0] levels(input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt,
                                               input logic [1:0] op, input int lo, input int hi);
      logic [WIDTH-1:0] r;
      r = d;
      for (int j = 0; j < SHW; j++)
         if (j >= lo && j < hi && amt[j]) r = step(r, op, 1 << j);
      levels = r;
   endfunction

   logic [PIPE-1:0]  vld;
   logic [PIPE-1:0]  adv;
   logic             run;
   logic [WIDTH-1:0] s_data [PIPE];
   logic [1:0]       s_op   [PIPE];
   logic [TAGW-1:0]  s_tag  [PIPE];
   logic [SHW-1:0]   a_in   [PIPE];

   // Stage k may advance when it or any later stage holds a hole, or the consumer takes the result.
   always_comb begin
      run = out_ready;
      adv = '0;
      for (int k = PIPE - 1; k >= 0; k--) begin
         run    = run | ~vld[k];
         adv[k] = run;
      end
   end

   assign in_ready = adv[0];
   assign a_in[0]  = in_amt;

   for (genvar k = 0; k < PIPE; k++) begin : g_stage
      localparam int LO = k * LPS;
      localparam int HI = (k + 1) * LPS < SHW ? (k + 1) * LPS : SHW;
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      logic [1:0]       src_o;
      logic [TAGW-1:0]  src_t;
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic [1:0]       op_q;
      logic [TAGW-1:0]  tag_q;
      if (k == 0) begin : g_head
         assign src_v = in_valid;
         assign src_d = (!ROT_EN && in_op == 2'b11) ? '0 : in_data;
         assign src_o = in_op;
         assign src_t = in_tag;
      end else begin : g_body
         assign src_v = vld[k-1];
         assign src_d = s_data[k-1];
         assign src_o = s_op[k-1];
         assign src_t = s_tag[k-1];
      end
      assign data_d = levels(src_d, a_in[k], src_o, LO, HI);
      // Stage register: payload only loads with a valid op so the output holds the last result.
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            tag_q   <= '0;
         end else if (adv[k]) begin
            valid_q <= src_v;
            if (src_v) begin
               data_q <= data_d;
               op_q   <= src_o;
               tag_q  <= src_t;
            end
         end
      if (k < PIPE - 1) begin : g_amt
         logic [SHW-1:0] amt_q;
         // Amount bits travel on for the levels of later stages.
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) amt_q <= '0;
            else if (adv[k] && src_v) amt_q <= a_in[k];
         assign a_in[k+1] = amt_q;
      end
      assign vld[k]    = valid_q;
      assign s_data[k] = data_q;
      assign s_op[k]   = op_q;
      assign s_tag[k]  = tag_q;
   end

   assign out_valid = vld[PIPE-1];
   assign out_data  = s_data[PIPE-1];
   assign out_tag   = s_tag[PIPE-1];
   assign out_err   = !ROT_EN && s_op[PIPE-1] == 2'b11;
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: scoreboard bench for shifter_pipe (WIDTH=32, PIPE=2, TAGW=4)
module tb_shifter_pipe;
   localparam int WIDTH = 32;
   localparam int PIPE  = 2;
   localparam int TAGW  = 4;
`ifdef SHIFTER_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = '0;
   logic [4:0]  in_amt = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic        out_err;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   shifter_pipe #(.WIDTH(WIDTH), .PIPE(PIPE), .TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_amt(in_amt), .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
   );

   function automatic logic [31:0] model_data(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
      logic [63:0] w;
      case (op)
         2'd0:    w = {32'd0, d << a};
         2'd1:    w = {32'd0, d >> a};
         2'd2:    w = {{32{d[31]}}, d} >> a;
         default: w = ROT_EN ? ({d, d} << a) >> 32 : 64'd0;
      endcase
      return w[31:0];
   endfunction

   function automatic logic model_err(input logic [1:0] op);
      return !ROT_EN && op == 2'd3;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_payload();
      in_op   = 2'($urandom);
      in_amt  = 5'($urandom);
      in_data = $urandom;
   endtask

   // Input side: every accepted op pushes its expected result.
   always @(negedge clk)
      if (rst_n && in_valid && in_ready) begin
         exp_t e;
         e.tag  = in_tag;
         e.data = model_data(in_op, in_amt, in_data);
         e.err  = model_err(in_op);
         sb.push_back(e);
      end

   // Output side: every delivered result is compared with the oldest expectation.
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         exp_t e;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got tag %0h data %0h with no op outstanding", out_tag, out_data);
         end else begin
            e = sb.pop_front();
            chk("sb_tag", 64'(out_tag), 64'(e.tag));
            chk("sb_data", 64'(out_data), 64'(e.data));
            chk("sb_err", 64'(out_err), 64'(e.err));
         end
      end

   task automatic run1(input string name, input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] t, input logic [31:0] ed, input logic ee);
      int n;
      in_valid = 1'b1;
      in_op = op;
      in_amt = a;
      in_data = d;
      in_tag = t;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'(PIPE));
      chk({name, "_data"}, 64'(out_data), 64'(ed));
      chk({name, "_err"}, 64'(out_err), 64'(ee));
      chk({name, "_tag"}, 64'(out_tag), 64'(t));
      tick();
   endtask

   initial begin
      int   idx, nacc, streak, seen, n;
      logic acc;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      run1("sll31", 2'd0, 5'd31, 32'h0000_0001, 4'd1, 32'h8000_0000, 1'b0);
      run1("srl4", 2'd1, 5'd4, 32'h8000_0000, 4'd2, 32'h0800_0000, 1'b0);
      run1("sra4_neg", 2'd2, 5'd4, 32'h8000_0000, 4'd3, 32'hF800_0000, 1'b0);
      run1("sra4_pos", 2'd2, 5'd4, 32'h7000_0000, 4'd4, 32'h0700_0000, 1'b0);
      run1("rol1", 2'd3, 5'd1, 32'h8000_0001, 4'd5, ROT_EN ? 32'h0000_0003 : 32'h0, !ROT_EN);
      for (int op = 0; op < 4; op++)
         run1("amt0", 2'(op), 5'd0, 32'hA5A5_5A5A, 4'(op + 9),
              (!ROT_EN && op == 3) ? 32'h0 : 32'hA5A5_5A5A, !ROT_EN && op == 3);

      // Back-pressure: consumer stalls, pipeline fills with two ops, then drains in order.
      out_ready = 1'b0;
      idx = 1;
      nacc = 0;
      in_valid = 1'b1;
      in_tag = 4'd1;
      new_payload();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) begin
            nacc++;
            idx++;
            in_tag = 4'(idx);
            new_payload();
         end
      end
      chk("bp_accepts", 64'(nacc), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      streak = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid) streak++;
         tick();
         if (acc) begin
            idx++;
            if (idx > 6) in_valid = 1'b0;
            else begin
               in_tag = 4'(idx);
               new_payload();
            end
         end
      end
      chk("bp_stream", 64'(streak), 64'd6);
      chk("bp_all_in", 64'(idx), 64'd7);

      // Reset with two ops in flight: both are discarded.
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_tag = 4'd7;
      new_payload();
      tick();
      in_tag = 4'd8;
      new_payload();
      tick();
      in_valid = 1'b0;
      chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         tick();
         if (out_valid) seen++;
      end
      chk("post_rst_stale", 64'(seen), 64'd0);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Random traffic with random back-pressure.
      repeat (400) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         in_tag = 4'($urandom);
         new_payload();
         if ($urandom_range(0, 3) == 0) in_amt = $urandom_range(0, 1) != 0 ? 5'd31 : 5'd0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_outstanding", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
